arg_task_packer: RTL and testbench

- Inverse of the sync PE data path. The sync PE consumes 128-bit task beats and emits the 64-bit upper half as an argument.
- This block consumes a stream of 64-bit argument beats, pairs consecutive beats into one 128-bit task, and emits it on an AXI-Stream task port.
- Sits between an argument producer (e.g. sync/continuation logic) and a task queue input.
- Fully pipelined with a 2-entry output buffer, so all ready signals are driven from registers only.

---
 rtl/arg_task_packer_pkg.sv | 21 ++
 rtl/arg_task_packer_if.sv | 31 +++
 rtl/arg_task_packer_task_skid_buffer.sv | 61 ++++++
 rtl/arg_task_packer.sv | 90 +++++++++
 tb/tb_arg_task_packer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arg_task_packer_pkg.sv
// Shared definitions for the argument-to-task packing path.
// The task type is also used by the sync PE and the task queues.
package arg_task_pkg;

  localparam int ARG_WIDTH  = 64;
  localparam int TASK_WIDTH = 128;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } packer_state_t;

  typedef logic [TASK_WIDTH-1:0] task_t;

  // The first beat lands in the low half, the second beat in the high half.
  function automatic task_t pack_task(input logic [ARG_WIDTH-1:0] high_half,
                                      input logic [ARG_WIDTH-1:0] low_half);
    return {high_half, low_half};
  endfunction

endpackage

// File: rtl/arg_task_packer_if.sv
// Argument-in and task-out AXI-Stream bundle for the packer.
// master is the environment side, slave is the packer side.
interface arg_task_packer_if;
  import arg_task_pkg::*;

  logic [ARG_WIDTH-1:0]  argIn_TDATA;
  logic                  argIn_TVALID;
  logic                  argIn_TREADY;
  logic [TASK_WIDTH-1:0] taskOut_TDATA;
  logic                  taskOut_TVALID;
  logic                  taskOut_TREADY;

  modport master (
    output argIn_TDATA,
    output argIn_TVALID,
    input  argIn_TREADY,
    input  taskOut_TDATA,
    input  taskOut_TVALID,
    output taskOut_TREADY
  );

  modport slave (
    input  argIn_TDATA,
    input  argIn_TVALID,
    output argIn_TREADY,
    output taskOut_TDATA,
    output taskOut_TVALID,
    input  taskOut_TREADY
  );

endinterface

// File: rtl/arg_task_packer_task_skid_buffer.sv
// Two-entry valid/ready FIFO holding packed tasks; head entry drives the output.
// count_lt2 comes straight from the count register so upstream ready stays registered.
module task_skid_buffer
  import arg_task_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  task_t data_in,
  output logic  count_lt2,
  output logic  tvalid,
  output task_t tdata,
  input  logic  tready
);

  logic [1:0] count_q;
  task_t      head_q;
  task_t      tail_q;
  logic       pop;

  assign tvalid    = !rst && (count_q != 2'd0);
  assign tdata     = tvalid ? head_q : '0;
  assign count_lt2 = (count_q < 2'd2);
  assign pop       = tvalid && tready;

  // Simultaneous push/pop keeps the count; the new entry goes behind whatever stays.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_q <= data_in;
          end else begin
            tail_q <= data_in;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          tail_q  <= '0;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= data_in;
          end else begin
            head_q <= tail_q;
            tail_q <= data_in;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/arg_task_packer.sv
// Pairs consecutive 64-bit argument beats into 128-bit tasks and streams them out.
// A half-held low beat plus a two-entry buffer lets the input run at full rate.
module arg_task_packer
  import arg_task_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  arg_task_packer_if.slave     bus,
  output logic [CNT_WIDTH-1:0] tasks_packed
);

  packer_state_t        state_q;
  packer_state_t        state_d;
  logic [ARG_WIDTH-1:0] low_q;
  logic [ARG_WIDTH-1:0] low_d;
  logic                 count_lt2;
  logic                 push;
  task_t                push_data;
  logic                 arg_ready;
  logic                 out_valid;
  task_t                out_data;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= LOW;
      low_q   <= '0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
    end
  end

  // In HIGH the second beat is only taken when the buffer has room for the task.
  always_comb begin
    state_d   = state_q;
    low_d     = low_q;
    push      = 1'b0;
    push_data = '0;
    arg_ready = 1'b0;
    if (!ap_rst) begin
      case (state_q)
        LOW: begin
          arg_ready = 1'b1;
          if (bus.argIn_TVALID) begin
            low_d   = bus.argIn_TDATA;
            state_d = HIGH;
          end
        end
        HIGH: begin
          arg_ready = count_lt2;
          if (bus.argIn_TVALID && count_lt2) begin
            push      = 1'b1;
            push_data = pack_task(bus.argIn_TDATA, low_q);
            state_d   = LOW;
          end
        end
        default: begin
          state_d = LOW;
        end
      endcase
    end
  end

  assign bus.argIn_TREADY = arg_ready;

  task_skid_buffer u_skid (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .push      (push),
    .data_in   (push_data),
    .count_lt2 (count_lt2),
    .tvalid    (out_valid),
    .tdata     (out_data),
    .tready    (bus.taskOut_TREADY)
  );

  assign bus.taskOut_TVALID = out_valid;
  assign bus.taskOut_TDATA  = out_data;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      tasks_packed <= '0;
    end else if (out_valid && bus.taskOut_TREADY) begin
      tasks_packed <= tasks_packed + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_arg_task_packer.sv
// Bench for arg_task_packer: queue-based model checked every cycle plus directed literal checks.
// A second instance with a 4-bit counter shares the same stimulus to exercise counter wrap.
module tb_arg_task_packer;
  import arg_task_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic [31:0] tasks_packed;
  logic [3:0]  tasks_packed4;

  always #5 ap_clk = ~ap_clk;

  arg_task_packer_if bus ();
  arg_task_packer_if bus4 ();

  arg_task_packer #(.CNT_WIDTH(32)) dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .bus          (bus),
    .tasks_packed (tasks_packed)
  );

  arg_task_packer #(.CNT_WIDTH(4)) dut4 (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .bus          (bus4),
    .tasks_packed (tasks_packed4)
  );

  assign bus4.argIn_TDATA   = bus.argIn_TDATA;
  assign bus4.argIn_TVALID  = bus.argIn_TVALID;
  assign bus4.taskOut_TREADY = bus.taskOut_TREADY;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] tx_q[$];
  task_t       exp_q[$];
  task_t       log_q[$];
  bit          have_low = 1'b0;
  logic [63:0] low_m = '0;
  logic [31:0] cnt_m = '0;
  bit          model_on = 1'b0;
  bit          m_ready;
  bit          m_pop;
  logic        exp_v;
  int          dut_accepted = 0;
  int          ready_low_seen = 0;
  int          tready_mode = 1;
  int          gap_pct = 0;
  logic        s_fire = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready = 1'b0;
  task_t       s_tdata = '0;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Snapshot DUT outputs away from the edge and compare against the model.
  always @(negedge ap_clk) begin
    s_fire   = bus.argIn_TVALID && bus.argIn_TREADY;
    s_tvalid = bus.taskOut_TVALID;
    s_tready = bus.taskOut_TREADY;
    s_tdata  = bus.taskOut_TDATA;
    if (s_fire) dut_accepted++;
    if (!bus.argIn_TREADY) ready_low_seen++;
    if (model_on) begin
      exp_v = !ap_rst && (exp_q.size() != 0);
      check_output("tvalid", bus.taskOut_TVALID, exp_v);
      check_output("tdata", bus.taskOut_TDATA, exp_v ? exp_q[0] : '0);
      check_output("arg_ready", bus.argIn_TREADY, !ap_rst && (!have_low || exp_q.size() < 2));
      check_output("tasks_packed", tasks_packed, cnt_m);
      check_output("tvalid_w4", bus4.taskOut_TVALID, exp_v);
      check_output("tasks_packed_w4", tasks_packed4, cnt_m[3:0]);
    end
  end

  // Reference model: a held low half plus a queue of at most two finished tasks.
  always @(posedge ap_clk) begin
    if (ap_rst) begin
      have_low = 1'b0;
      low_m    = '0;
      exp_q.delete();
      cnt_m    = '0;
      model_on = 1'b1;
    end else if (model_on) begin
      m_ready = !have_low || (exp_q.size() < 2);
      m_pop   = (exp_q.size() != 0) && bus.taskOut_TREADY;
      if (m_pop) begin
        void'(exp_q.pop_front());
        cnt_m = cnt_m + 32'd1;
      end
      if (bus.argIn_TVALID && m_ready) begin
        if (have_low) begin
          exp_q.push_back({bus.argIn_TDATA, low_m});
          have_low = 1'b0;
        end else begin
          low_m    = bus.argIn_TDATA;
          have_low = 1'b1;
        end
      end
    end
    if (!ap_rst && s_tvalid && s_tready) log_q.push_back(s_tdata);
  end

  // Stream driver: holds a beat until it is taken, optional random gaps and backpressure.
  always @(posedge ap_clk) begin
    if (s_fire && tx_q.size() != 0) void'(tx_q.pop_front());
    #1;
    if (ap_rst) begin
      bus.argIn_TVALID = 1'b0;
    end else if (!bus.argIn_TVALID || s_fire) begin
      if (tx_q.size() != 0 && $urandom_range(99) >= gap_pct) begin
        bus.argIn_TVALID = 1'b1;
        bus.argIn_TDATA  = tx_q[0];
      end else begin
        bus.argIn_TVALID = 1'b0;
      end
    end
    case (tready_mode)
      0:       bus.taskOut_TREADY = 1'b0;
      1:       bus.taskOut_TREADY = 1'b1;
      default: bus.taskOut_TREADY = 1'($urandom_range(1));
    endcase
  end

  task automatic step(input int n);
    repeat (n) @(posedge ap_clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic [63:0] beat);
    tx_q.push_back(beat);
  endtask

  task automatic do_reset();
    tx_q.delete();
    ap_rst = 1'b1;
    step(2);
    ap_rst = 1'b0;
    step(1);
    dut_accepted = 0;
    log_q.delete();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((tx_q.size() != 0 || exp_q.size() != 0 || bus.argIn_TVALID) && n < budget) begin
      step(1);
      n++;
    end
    tests++;
    if (n >= budget) begin
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d cycles required < %0d", n, budget);
    end
    step(2);
  endtask

  task automatic wait_accepted(input int target, input int budget);
    int n = 0;
    while (dut_accepted < target && n < budget) begin
      step(1);
      n++;
    end
    tests++;
    if (n >= budget) begin
      fails++;
      $display("[TB] FAIL accept_timeout: got %0d beats required %0d", dut_accepted, target);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bus.argIn_TVALID   = 1'b0;
    bus.argIn_TDATA    = '0;
    bus.taskOut_TREADY = 1'b0;

    // Reset state
    step(3);
    check_output("reset_tvalid", bus.taskOut_TVALID, 1'b0);
    check_output("reset_tdata", bus.taskOut_TDATA, 128'h0);
    check_output("reset_ready", bus.argIn_TREADY, 1'b0);
    check_output("reset_count", tasks_packed, 32'd0);
    ap_rst = 1'b0;
    step(1);
    check_output("post_reset_ready", bus.argIn_TREADY, 1'b1);

    // Pairing
    apply_stimulus(64'h1111_1111_1111_1111);
    apply_stimulus(64'h2222_2222_2222_2222);
    n = 0;
    while (!bus.taskOut_TVALID && n < 20) begin
      step(1);
      n++;
    end
    check_output("pair_tdata", bus.taskOut_TDATA, 128'h2222_2222_2222_2222_1111_1111_1111_1111);
    wait_drain(50);
    check_output("pair_count", tasks_packed, 32'd1);

    // Streaming
    do_reset();
    ready_low_seen = 0;
    for (int i = 0; i < 8; i++) apply_stimulus(64'(i));
    wait_drain(100);
    check_output("stream_ready_low", ready_low_seen, 0);
    check_output("stream_count", tasks_packed, 32'd4);
    check_output("stream_ntasks", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      check_output("stream_task", log_q[i], {64'(2*i+1), 64'(2*i)});

    // Backpressure
    do_reset();
    tready_mode = 0;
    for (int i = 0; i < 7; i++) apply_stimulus(64'(i));
    step(20);
    check_output("bp_accepted", dut_accepted, 5);
    check_output("bp_ready", bus.argIn_TREADY, 1'b0);
    check_output("bp_tvalid", bus.taskOut_TVALID, 1'b1);
    tready_mode = 1;
    wait_drain(100);
    check_output("bp_ntasks", log_q.size(), 3);
    for (int i = 0; i < 3 && i < log_q.size(); i++)
      check_output("bp_task", log_q[i], {64'(2*i+1), 64'(2*i)});
    check_output("bp_accepted_all", dut_accepted, 7);

    // Simultaneous push and pop
    do_reset();
    tready_mode = 0;
    apply_stimulus(64'hA000_0000_0000_000A);
    apply_stimulus(64'hB000_0000_0000_000B);
    apply_stimulus(64'hC000_0000_0000_000C);
    wait_accepted(3, 50);
    tready_mode = 1;
    apply_stimulus(64'hD000_0000_0000_000D);
    wait_drain(50);
    check_output("pp_ntasks", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check_output("pp_task0", log_q[0], 128'hB000_0000_0000_000B_A000_0000_0000_000A);
      check_output("pp_task1", log_q[1], 128'hD000_0000_0000_000D_C000_0000_0000_000C);
    end
    check_output("pp_count", tasks_packed, 32'd2);

    // Reset mid-task
    do_reset();
    apply_stimulus(64'hAA);
    wait_accepted(1, 50);
    ap_rst = 1'b1;
    step(1);
    ap_rst = 1'b0;
    step(1);
    check_output("midrst_count0", tasks_packed, 32'd0);
    log_q.delete();
    apply_stimulus(64'hBB);
    apply_stimulus(64'hCC);
    wait_drain(50);
    check_output("midrst_ntasks", log_q.size(), 1);
    if (log_q.size() == 1) check_output("midrst_task", log_q[0], {64'hCC, 64'hBB});
    check_output("midrst_count1", tasks_packed, 32'd1);

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      apply_stimulus({$urandom, $urandom});
      apply_stimulus({$urandom, $urandom});
      wait_drain(50);
      if (k == 15) check_output("wrap_15", tasks_packed4, 4'd15);
      if (k == 16) check_output("wrap_16", tasks_packed4, 4'd0);
      if (k == 17) check_output("wrap_17", tasks_packed4, 4'd1);
    end
    check_output("wrap_count32", tasks_packed, 32'd17);

    // Randomized traffic with random gaps and backpressure
    do_reset();
    tready_mode = 2;
    gap_pct = 30;
    for (int i = 0; i < 400; i++) apply_stimulus({$urandom, $urandom});
    wait_drain(5000);
    gap_pct = 0;
    tready_mode = 1;
    check_output("rand_count", tasks_packed, 32'd200);
    check_output("rand_ntasks", log_q.size(), 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
